// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//
// Single-outstanding APB3 requester. A valid/ready command from the system
// side becomes one APB transfer (SETUP, then ACCESS until Pready). The result
// comes back as a one-cycle rsp_valid pulse carrying read data and error
// status. A wait-state limit aborts an ACCESS phase that a hung slave never
// completes.
//
// Handshake: a command transfers on a rising Pclk edge where cmd_valid and
// cmd_ready are both 1. The command fields are sampled only on that edge. The
// requester holds cmd_valid until the transfer happens. rsp_valid has no
// backpressure and is high for exactly one cycle per completed transfer.
//
// Ports:
//   Pclk, Prst            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_write/addr/wdata  command fields (wdata ignored for reads)
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data (0 for writes and timeouts)
//   rsp_err/rsp_timeout   slave error or timeout, and timeout-only flag
//   Paddr..Pwdata         APB requester outputs
//   Pready/Pslverr/Prdata APB slave inputs
//   state_dbg             current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
module apb_master_bridge #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Wait counter value on the last allowed ACCESS cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  assign state_dbg = state;

  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      Paddr       <= '0;
      Pselx       <= 1'b0;
      Penable     <= 1'b0;
      Pwrite      <= 1'b0;
      Pwdata      <= '0;
    end else begin
      // The response pulse lasts one cycle unless a completion below
      // sets it again.
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            Paddr     <= cmd_addr;
            Pwrite    <= cmd_write;
            Pwdata    <= cmd_write ? cmd_wdata : '0;
            Pselx     <= 1'b1;
            Penable   <= 1'b0;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // Pready is not looked at here, so ACCESS always lasts at
          // least one cycle.
          Penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (Pready) begin
            rsp_rdata   <= Pwrite ? '0 : Prdata;
            rsp_err     <= Pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            Pselx       <= 1'b0;
            Penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            Pselx       <= 1'b0;
            Penable     <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          Pselx     <= 1'b0;
          Penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3 requester that drives the APB_Memory slave's bus (Paddr, Pselx, Penable, Pwrite, Pwdata).
- Converts a simple valid/ready command port from the system side into compliant SETUP/ACCESS phases and returns read data and error status as a one-cycle response pulse.
- Adds a bounded wait-state timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_W, 6, APB address width; matches the slave memory depth of 64 words.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles with Pready low before abort; legal range 1..255.

Ports:
- Pclk  in  1  rising-edge clock.
- Prst  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  Pslverr sampled at completion, or timeout.
- rsp_timeout  out  1  completion was a timeout abort.
- Paddr  out  ADDR_W  APB address.
- Pselx  out  1  APB select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Pwdata  out  DATA_W  APB write data.
- Pready  in  1  slave ready.
- Pslverr  in  1  slave error.
- Prdata  in  DATA_W  slave read data.

Behaviour:
- All outputs are registered.
- Reset values (Prst low, asynchronous): state IDLE; cmd_ready=1; all other outputs 0; wait counter 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1, Pselx=0, Penable=0.
  - cmd_valid=1 at a rising edge: latch cmd_write, cmd_addr and cmd_wdata into Pwrite, Paddr and Pwdata. For reads, Pwdata is driven to 0.
  - Next state is SETUP; cmd_ready drops to 0.
- SETUP (exactly one cycle): Pselx=1, Penable=0. Next state is ACCESS.
- ACCESS: Pselx=1, Penable=1. At each rising edge:
  - If Pready=1: capture Prdata into rsp_rdata (reads only; 0 for writes). Capture Pslverr into rsp_err. Set rsp_timeout=0 and rsp_valid=1. Drop Pselx and Penable to 0 and go to IDLE.
  - Else if the wait counter equals TIMEOUT-1: abort. Set rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Drop Pselx and Penable and go to IDLE.
  - Else increment the wait counter. The counter clears on entry to SETUP.
- Paddr, Pwrite and Pwdata stay stable from SETUP through the last ACCESS cycle. They hold their last value while IDLE.
- rsp_valid is high for exactly one cycle, the first IDLE cycle after completion. It has no backpressure. rsp_rdata, rsp_err and rsp_timeout hold their values until the next completion.
- cmd_ready is high in that same cycle. A new command is accepted there, which gives back-to-back transfers of 3 cycles minimum (SETUP, ACCESS, IDLE).
- Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2. With zero wait states, rsp_valid is high in cycle N+3.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold cmd_valid until accepted. Command inputs are only sampled at the accept edge.
- Pslverr and Prdata are ignored whenever Pready=0.
- Reset asserted mid-transfer: Pselx and Penable drop immediately (asynchronously). The transfer is discarded, no rsp_valid is generated, and the FSM returns to IDLE.
- Pready high during SETUP has no effect; ACCESS always lasts at least one cycle.

Test Plan:
- Reset then write 0xDEADBEEF to 0x05 with Pready tied 1 → Pselx=1/Penable=0 for 1 cycle, then 1/1 for 1 cycle. Paddr=5, Pwrite=1, Pwdata=0xDEADBEEF throughout. rsp_valid pulses 3 cycles after accept with rsp_err=0.
- Read 0x05 from the APB_Memory model after the previous write → rsp_rdata=0xDEADBEEF, rsp_err=0. Pwdata=0 during the transfer.
- Slave inserts 3 wait states (Pready low for 3 ACCESS cycles) → Penable held for 4 cycles with Paddr stable. rsp_valid 6 cycles after accept.
- Pready held low, TIMEOUT=16 → exactly 16 ACCESS cycles, then Pselx=0. rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Write with Pslverr=1 at Pready → rsp_err=1, rsp_timeout=0. Back-to-back: cmd_valid held for 2 commands → second SETUP begins exactly 3 cycles after the first.
- Prst pulsed low during ACCESS → Pselx and Penable go 0 immediately, no rsp_valid. The next command after reset completes normally.
